// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell and winner codes, FSM states and the
// table of the eight winning lines used by the sequencer and display tests.
package ttt_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b01,
        CELL_O     = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_X    = 2'b01,
        WIN_O    = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SCAN,
        DONE
    } state_t;

    // Each entry packs three cell indices {a, b, c}: rows, columns, diagonal, anti-diagonal.
    localparam logic [11:0] LINE_TABLE [8] = '{
        {4'd0, 4'd1, 4'd2},
        {4'd3, 4'd4, 4'd5},
        {4'd6, 4'd7, 4'd8},
        {4'd0, 4'd3, 4'd6},
        {4'd1, 4'd4, 4'd7},
        {4'd2, 4'd5, 4'd8},
        {4'd0, 4'd4, 4'd8},
        {4'd2, 4'd4, 4'd6}
    };

    // Indices past the board read as 2'b11 so they never match empty or a mark.
    function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] idx);
        cell_at = 2'b11;
        for (int i = 0; i < 9; i++) begin
            if (idx == 4'(i)) begin
                cell_at = board[2*i +: 2];
            end
        end
    endfunction

endpackage

// File: rtl/win_line_rom.sv
// Combinational lookup from a win-line index to its three board cell indices.
module win_line_rom
    import ttt_pkg::*;
(
    input  logic [2:0] line_idx,
    output logic [3:0] cell_a,
    output logic [3:0] cell_b,
    output logic [3:0] cell_c
);

    assign {cell_a, cell_b, cell_c} = LINE_TABLE[line_idx];

endmodule

// File: rtl/move_sequencer.sv
// Turn controller for the tic-tac-toe board: arbitrates X/O move requests,
// validates and writes moves, then scans the eight lines for a win or draw.
module move_sequencer
    import ttt_pkg::*;
(
    input  logic        ph1,
    input  logic        reset,
    input  logic        new_game,
    input  logic        x_req,
    input  logic [1:0]  x_row,
    input  logic [1:0]  x_col,
    input  logic        o_req,
    input  logic [1:0]  o_row,
    input  logic [1:0]  o_col,
    output logic        x_ack,
    output logic        x_nack,
    output logic        o_ack,
    output logic        o_nack,
    output logic [17:0] registers,
    output logic        turn,
    output logic        game_over,
    output logic [1:0]  winner
);

    state_t     state;
    logic [1:0] row_q;
    logic [1:0] col_q;
    logic [3:0] move_count;
    logic [2:0] line_idx;

    logic [3:0] cell_idx;
    logic [3:0] cell_a;
    logic [3:0] cell_b;
    logic [3:0] cell_c;
    logic [1:0] mark;
    logic       cur_req;
    logic       cur_busy;
    logic       move_legal;
    logic       line_hit;

    win_line_rom u_win_line_rom (
        .line_idx (line_idx),
        .cell_a   (cell_a),
        .cell_b   (cell_b),
        .cell_c   (cell_c)
    );

    // The player whose turn it is is always the mover, so turn selects everything.
    assign cur_req    = turn ? o_req : x_req;
    assign cur_busy   = turn ? (o_ack | o_nack) : (x_ack | x_nack);
    assign mark       = turn ? CELL_O : CELL_X;
    assign cell_idx   = ({2'b00, row_q} * 4'd3) + {2'b00, col_q};
    assign move_legal = (row_q != 2'd3) && (col_q != 2'd3) &&
                        (cell_at(registers, cell_idx) == CELL_EMPTY);
    assign line_hit   = (cell_at(registers, cell_a) == mark) &&
                        (cell_at(registers, cell_b) == mark) &&
                        (cell_at(registers, cell_c) == mark);

    always_ff @(posedge ph1) begin
        if (reset || new_game) begin
            state      <= IDLE;
            row_q      <= 2'd0;
            col_q      <= 2'd0;
            move_count <= 4'd0;
            line_idx   <= 3'd0;
            registers  <= 18'd0;
            turn       <= 1'b0;
            game_over  <= 1'b0;
            winner     <= WIN_NONE;
            x_ack      <= 1'b0;
            x_nack     <= 1'b0;
            o_ack      <= 1'b0;
            o_nack     <= 1'b0;
        end else begin
            x_ack  <= 1'b0;
            x_nack <= 1'b0;
            o_ack  <= 1'b0;
            o_nack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cur_req && !cur_busy) begin
                        row_q <= turn ? o_row : x_row;
                        col_q <= turn ? o_col : x_col;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!move_legal) begin
                        if (turn) o_nack <= 1'b1;
                        else      x_nack <= 1'b1;
                        state <= IDLE;
                    end else begin
                        for (int i = 0; i < 9; i++) begin
                            if (cell_idx == 4'(i)) begin
                                registers[2*i +: 2] <= mark;
                            end
                        end
                        if (turn) o_ack <= 1'b1;
                        else      x_ack <= 1'b1;
                        move_count <= move_count + 4'd1;
                        line_idx   <= 3'd0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (line_hit) begin
                        game_over <= 1'b1;
                        winner    <= turn ? WIN_O : WIN_X;
                        state     <= DONE;
                    end else if (line_idx != 3'd7) begin
                        line_idx <= line_idx + 3'd1;
                    end else if (move_count == 4'd9) begin
                        game_over <= 1'b1;
                        winner    <= WIN_DRAW;
                        state     <= DONE;
                    end else begin
                        turn  <= ~turn;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: table-driven games plus hand-written
// sequences for pending requests, ignored requests and mid-scan new_game.
module tb_move_sequencer;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        new_game;
    logic        x_req;
    logic [1:0]  x_row;
    logic [1:0]  x_col;
    logic        o_req;
    logic [1:0]  o_row;
    logic [1:0]  o_col;
    logic        x_ack;
    logic        x_nack;
    logic        o_ack;
    logic        o_nack;
    logic [17:0] registers;
    logic        turn;
    logic        game_over;
    logic [1:0]  winner;

    move_sequencer dut (
        .ph1       (ph1),
        .reset     (reset),
        .new_game  (new_game),
        .x_req     (x_req),
        .x_row     (x_row),
        .x_col     (x_col),
        .o_req     (o_req),
        .o_row     (o_row),
        .o_col     (o_col),
        .x_ack     (x_ack),
        .x_nack    (x_nack),
        .o_ack     (o_ack),
        .o_nack    (o_nack),
        .registers (registers),
        .turn      (turn),
        .game_over (game_over),
        .winner    (winner)
    );

    always #5 ph1 = ~ph1;

    typedef struct {
        logic        fresh;
        logic        player;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        exp_ack;
        logic [17:0] exp_regs;
        logic        exp_turn;
        logic        exp_over;
        logic [1:0]  exp_winner;
        int          exp_settle;
    } move_vec_t;

    move_vec_t  vecs[$];
    logic [3:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Every response pulse must match the oldest expected response in order.
    always @(negedge ph1) begin : response_monitor
        logic [3:0] resp;
        logic [3:0] want;
        resp = {x_ack, x_nack, o_ack, o_nack};
        if (resp != 4'b0000) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_response", 32'(resp), 32'd0);
            end else begin
                want = exp_q.pop_front();
                checkOutput("response", 32'(resp), 32'(want));
            end
        end
    end

    task automatic addVec(input logic fresh, input logic player, input logic [1:0] row, input logic [1:0] col,
                          input logic ack, input logic [17:0] regs, input logic t, input logic over,
                          input logic [1:0] win, input int settle);
        move_vec_t v;
        v.fresh = fresh; v.player = player; v.row = row; v.col = col; v.exp_ack = ack;
        v.exp_regs = regs; v.exp_turn = t; v.exp_over = over; v.exp_winner = win; v.exp_settle = settle;
        vecs.push_back(v);
    endtask

    task automatic pulseNewGame();
        @(negedge ph1);
        new_game = 1'b1;
        @(negedge ph1);
        new_game = 1'b0;
    endtask

    task automatic applyStimulus(input move_vec_t v);
        int   lat;
        int   settle;
        logic got;
        logic got_ack;
        logic t0;
        if (v.fresh) pulseNewGame();
        @(negedge ph1);
        if (v.player) exp_q.push_back(v.exp_ack ? 4'b0010 : 4'b0001);
        else          exp_q.push_back(v.exp_ack ? 4'b1000 : 4'b0100);
        if (v.player) begin o_req = 1'b1; o_row = v.row; o_col = v.col; end
        else          begin x_req = 1'b1; x_row = v.row; x_col = v.col; end
        lat = 0; got = 1'b0; got_ack = 1'b0;
        while (!got && lat < 20) begin
            @(negedge ph1);
            lat++;
            if (v.player ? (o_ack | o_nack) : (x_ack | x_nack)) begin
                got = 1'b1;
                got_ack = v.player ? o_ack : x_ack;
            end
        end
        x_req = 1'b0;
        o_req = 1'b0;
        checkOutput("resp_latency", 32'(lat), 32'd2);
        checkOutput("ack_kind", 32'(got_ack), 32'(v.exp_ack));
        if (v.exp_ack) begin
            t0 = turn;
            settle = 0;
            while (turn == t0 && !game_over && settle < 20) begin
                @(negedge ph1);
                settle++;
            end
            checkOutput("settle_cycles", 32'(settle), 32'(v.exp_settle));
        end else begin
            repeat (2) @(negedge ph1);
        end
        checkOutput("registers", 32'(registers), 32'(v.exp_regs));
        checkOutput("turn", 32'(turn), 32'(v.exp_turn));
        checkOutput("game_over", 32'(game_over), 32'(v.exp_over));
        checkOutput("winner", 32'(winner), 32'(v.exp_winner));
    endtask

    initial begin
        int        cnt;
        move_vec_t v;
        reset = 1'b1; new_game = 1'b0;
        x_req = 1'b0; x_row = 2'd0; x_col = 2'd0;
        o_req = 1'b0; o_row = 2'd0; o_col = 2'd0;
        repeat (3) @(negedge ph1);
        reset = 1'b0;
        @(negedge ph1);
        checkOutput("reset_registers", 32'(registers), 32'd0);
        checkOutput("reset_turn", 32'(turn), 32'd0);
        checkOutput("reset_game_over", 32'(game_over), 32'd0);
        checkOutput("reset_winner", 32'(winner), 32'd0);
        checkOutput("reset_acks", 32'({x_ack, x_nack, o_ack, o_nack}), 32'd0);

        // fresh player row col ack regs turn over winner settle
        addVec(1'b0, 1'b0, 2'd1, 2'd1, 1'b1, 18'h00100, 1'b1, 1'b0, 2'b00, 8);
        addVec(1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 18'h00100, 1'b1, 1'b0, 2'b00, 0);
        addVec(1'b0, 1'b1, 2'd1, 2'd3, 1'b0, 18'h00100, 1'b1, 1'b0, 2'b00, 0);
        addVec(1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 18'h00100, 1'b1, 1'b0, 2'b00, 0);
        addVec(1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 18'h00001, 1'b1, 1'b0, 2'b00, 8);
        addVec(1'b0, 1'b1, 2'd1, 2'd0, 1'b1, 18'h00081, 1'b0, 1'b0, 2'b00, 8);
        addVec(1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 18'h00085, 1'b1, 1'b0, 2'b00, 8);
        addVec(1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 18'h00285, 1'b0, 1'b0, 2'b00, 8);
        addVec(1'b0, 1'b0, 2'd0, 2'd2, 1'b1, 18'h00295, 1'b0, 1'b1, 2'b01, 1);
        addVec(1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 18'h00001, 1'b1, 1'b0, 2'b00, 8);
        addVec(1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 18'h00009, 1'b0, 1'b0, 2'b00, 8);
        addVec(1'b0, 1'b0, 2'd0, 2'd2, 1'b1, 18'h00019, 1'b1, 1'b0, 2'b00, 8);
        addVec(1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 18'h00219, 1'b0, 1'b0, 2'b00, 8);
        addVec(1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 18'h00259, 1'b1, 1'b0, 2'b00, 8);
        addVec(1'b0, 1'b1, 2'd1, 2'd2, 1'b1, 18'h00A59, 1'b0, 1'b0, 2'b00, 8);
        addVec(1'b0, 1'b0, 2'd2, 2'd1, 1'b1, 18'h04A59, 1'b1, 1'b0, 2'b00, 8);
        addVec(1'b0, 1'b1, 2'd2, 2'd0, 1'b1, 18'h06A59, 1'b0, 1'b0, 2'b00, 8);
        addVec(1'b0, 1'b0, 2'd2, 2'd2, 1'b1, 18'h16A59, 1'b0, 1'b1, 2'b11, 8);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Game is over: both players' requests must be ignored entirely.
        @(negedge ph1);
        x_req = 1'b1; x_row = 2'd1; x_col = 2'd1;
        o_req = 1'b1; o_row = 2'd0; o_col = 2'd1;
        repeat (20) @(negedge ph1);
        x_req = 1'b0; o_req = 1'b0;
        checkOutput("done_registers", 32'(registers), 32'h16A59);
        checkOutput("done_game_over", 32'(game_over), 32'd1);
        checkOutput("done_winner", 32'(winner), 32'd3);

        // O requests during X's turn stay pending and are served after the toggle.
        pulseNewGame();
        @(negedge ph1);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0010);
        x_req = 1'b1; x_row = 2'd1; x_col = 2'd1;
        o_req = 1'b1; o_row = 2'd0; o_col = 2'd0;
        cnt = 0;
        while (!x_ack && cnt < 20) begin @(negedge ph1); cnt++; end
        x_req = 1'b0;
        checkOutput("pending_x_latency", 32'(cnt), 32'd2);
        checkOutput("pending_x_registers", 32'(registers), 32'h00100);
        cnt = 0;
        while (!o_ack && cnt < 30) begin @(negedge ph1); cnt++; end
        o_req = 1'b0;
        checkOutput("pending_o_delay", 32'(cnt), 32'd10);
        checkOutput("pending_o_registers", 32'(registers), 32'h00102);
        checkOutput("pending_o_turn", 32'(turn), 32'd1);
        repeat (8) @(negedge ph1);
        checkOutput("pending_o_turn_back", 32'(turn), 32'd0);

        // new_game during SCAN with x_req high clears everything and drops the request.
        pulseNewGame();
        @(negedge ph1);
        exp_q.push_back(4'b1000);
        x_req = 1'b1; x_row = 2'd2; x_col = 2'd2;
        cnt = 0;
        while (!x_ack && cnt < 20) begin @(negedge ph1); cnt++; end
        x_req = 1'b0;
        checkOutput("scan_x_registers", 32'(registers), 32'h10000);
        repeat (2) @(negedge ph1);
        x_req = 1'b1; x_row = 2'd0; x_col = 2'd0;
        new_game = 1'b1;
        @(negedge ph1);
        checkOutput("ng_registers", 32'(registers), 32'd0);
        checkOutput("ng_turn", 32'(turn), 32'd0);
        checkOutput("ng_game_over", 32'(game_over), 32'd0);
        checkOutput("ng_winner", 32'(winner), 32'd0);
        checkOutput("ng_acks", 32'({x_ack, x_nack, o_ack, o_nack}), 32'd0);
        new_game = 1'b0;
        x_req = 1'b0;
        repeat (4) @(negedge ph1);
        checkOutput("ng_still_empty", 32'(registers), 32'd0);
        v.fresh = 1'b0; v.player = 1'b0; v.row = 2'd2; v.col = 2'd2; v.exp_ack = 1'b1;
        v.exp_regs = 18'h10000; v.exp_turn = 1'b1; v.exp_over = 1'b0; v.exp_winner = 2'b00; v.exp_settle = 8;
        applyStimulus(v);

        repeat (2) @(negedge ph1);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
